// File: rtl/sa_pkg.sv
// sa_pkg: shared constants and state type for the systolic-array operand feeder
package sa_pkg;
    localparam int DATA_WIDTH = 16;
    localparam logic [15:0] FP16_ZERO = 16'h0000;
    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} feeder_state_t;
endpackage

// File: rtl/sa_sync_fifo.sv
// sa_sync_fifo: power-of-two synchronous FIFO, no pass-through, full/empty from an occupancy count
module sa_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  empty,
    output logic                  full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic do_push, do_pop;
    assign empty = count_q == '0;
    assign full = count_q == FULL_CNT;
    assign do_push = push & !full;
    assign do_pop = pop & !empty;
    assign head = mem_q[rd_ptr_q];
    // pointers wrap naturally at DEPTH; occupancy tracks push minus pop
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, do_pop};
        count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
    // pointer and count registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
        end
    end
    // storage needs no reset; occupancy alone decides validity
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/sa_operand_feeder.sv
// sa_operand_feeder: A-operand chain feeder with bubbles and NUM_PE flush beats; FEEDER_BUBBLE_CNT_EN adds bubble_cnt
module sa_operand_feeder #(
    parameter int DATA_WIDTH = sa_pkg::DATA_WIDTH,
    parameter int NUM_PE = 4,
    parameter int DEPTH = 8,
    parameter int LEN_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] feed_a,
    output logic                  feed_valid,
    output logic                  busy,
    output logic                  done
`ifdef FEEDER_BUBBLE_CNT_EN
    ,
    output logic [15:0]           bubble_cnt
`endif
);
    import sa_pkg::*;
    localparam int FW = $clog2(NUM_PE) + 1;
    localparam logic [DATA_WIDTH-1:0] ZERO = DATA_WIDTH'(FP16_ZERO);
    feeder_state_t state_q, state_d;
    logic [LEN_WIDTH-1:0] issue_cnt_q, issue_cnt_d, len_q, len_d;
    logic [FW-1:0] flush_cnt_q, flush_cnt_d;
    logic [DATA_WIDTH-1:0] feed_a_q, feed_a_d, head;
    logic feed_valid_q, feed_valid_d, pop, empty, full;
    sa_sync_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_fifo (
        .clk(clk), .reset(reset), .push(in_valid), .wdata(in_data),
        .pop(pop), .head(head), .empty(empty), .full(full)
    );
    assign in_ready = !full;
    assign feed_a = feed_a_q;
    assign feed_valid = feed_valid_q;
    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
    // burst sequencing: issue len operands (bubbling when starved), then NUM_PE zero beats
    always_comb begin
        state_d = state_q;
        issue_cnt_d = issue_cnt_q;
        len_d = len_q;
        flush_cnt_d = flush_cnt_q;
        feed_a_d = ZERO;
        feed_valid_d = 1'b0;
        pop = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                len_d = burst_len;
                issue_cnt_d = '0;
                state_d = burst_len == '0 ? DONE : STREAM;
            end
            STREAM: if (!empty) begin
                pop = 1'b1;
                feed_a_d = head;
                feed_valid_d = 1'b1;
                issue_cnt_d = issue_cnt_q + LEN_WIDTH'(1);
                if (issue_cnt_d == len_q) begin
                    state_d = FLUSH;
                    flush_cnt_d = '0;
                end
            end
            FLUSH: begin
                flush_cnt_d = flush_cnt_q + FW'(1);
                if (flush_cnt_q == FW'(NUM_PE - 1)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end
    // state, counters and the registered feed output
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            issue_cnt_q <= '0;
            len_q <= '0;
            flush_cnt_q <= '0;
            feed_a_q <= ZERO;
            feed_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            issue_cnt_q <= issue_cnt_d;
            len_q <= len_d;
            flush_cnt_q <= flush_cnt_d;
            feed_a_q <= feed_a_d;
            feed_valid_q <= feed_valid_d;
        end
    end
`ifdef FEEDER_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt_q, bubble_cnt_d;
    assign bubble_cnt = bubble_cnt_q;
    // saturating count of starved STREAM cycles, cleared when a burst starts
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (state_q == IDLE && start) bubble_cnt_d = '0;
        else if (state_q == STREAM && empty && bubble_cnt_q != 16'hFFFF) bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
    // bubble counter register
    always_ff @(posedge clk) begin
        if (!reset) bubble_cnt_q <= '0;
        else bubble_cnt_q <= bubble_cnt_d;
    end
`endif
endmodule

// File: tb/tb_sa_operand_feeder.sv
// tb_sa_operand_feeder: scoreboard bench for sa_operand_feeder (FEEDER_BUBBLE_CNT_EN checks bubble_cnt)
module tb_sa_operand_feeder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic [7:0] burst_len = '0;
    logic in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic in_ready, feed_valid, busy, done;
    logic [15:0] feed_a;
    int checks = 0;
    int errors = 0;
    logic [15:0] sb[$];
`ifdef FEEDER_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt;
`endif
    sa_operand_feeder dut (
        .clk(clk), .reset(reset), .start(start), .burst_len(burst_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .feed_a(feed_a), .feed_valid(feed_valid), .busy(busy), .done(done)
`ifdef FEEDER_BUBBLE_CNT_EN
        , .bubble_cnt(bubble_cnt)
`endif
    );
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [15:0] d);
        in_valid = 1'b1;
        in_data = d;
        if (in_ready) sb.push_back(d);
        tick;
        in_valid = 1'b0;
    endtask
    task automatic test_reset;
        reset = 1'b0;
        tick;
        tick;
        checks++;
        if (feed_a !== 16'h0 || feed_valid !== 1'b0) begin errors++; $display("FAIL reset_feed: feed_a=%h valid=%b, want 0000/0", feed_a, feed_valid); end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL reset_ctrl: busy=%b done=%b in_ready=%b, want 0/0/1", busy, done, in_ready); end
        reset = 1'b1;
        tick;
    endtask
    task automatic test_prefilled_burst(input int len, input string name);
        logic [15:0] exp;
        int dones = 0;
        burst_len = 8'(len);
        start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || feed_valid !== 1'b0) begin errors++; $display("FAIL %s_start: busy=%b valid=%b, want 1/0", name, busy, feed_valid); end
        for (int k = 1; k <= len + 6; k++) begin
            tick;
            checks++;
            if (feed_valid !== (k <= len)) begin errors++; $display("FAIL %s_valid k=%0d: got %b want %b", name, k, feed_valid, k <= len); end
            if (k <= len) begin
                exp = sb.size() != 0 ? sb.pop_front() : 16'hxxxx;
                checks++;
                if (feed_a !== exp) begin errors++; $display("FAIL %s_data k=%0d: got %h want %h", name, k, feed_a, exp); end
            end else begin
                checks++;
                if (feed_a !== 16'h0) begin errors++; $display("FAIL %s_zero k=%0d: got %h want 0000", name, k, feed_a); end
            end
            checks++;
            if (done !== (k == len + 4)) begin errors++; $display("FAIL %s_done k=%0d: got %b want %b", name, k, done, k == len + 4); end
            checks++;
            if (busy !== (k <= len + 4)) begin errors++; $display("FAIL %s_busy k=%0d: got %b want %b", name, k, busy, k <= len + 4); end
            dones += int'(done);
        end
        checks++;
        if (dones != 1) begin errors++; $display("FAIL %s_done_count: got %0d want 1", name, dones); end
    endtask
    task automatic test_prefill;
        push(16'h4000);
        push(16'h459a);
        push(16'hc866);
        test_prefilled_burst(3, "prefill");
`ifdef FEEDER_BUBBLE_CNT_EN
        checks++;
        if (bubble_cnt !== 16'd0) begin errors++; $display("FAIL prefill_bubbles: got %0d want 0", bubble_cnt); end
`endif
    endtask
    task automatic test_starved;
        logic [15:0] exp;
        logic exp_v;
        burst_len = 8'd2;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            in_valid = (k == 3 || k == 5);
            in_data = k == 3 ? 16'h4000 : 16'h459a;
            if (in_valid && in_ready) sb.push_back(in_data);
            tick;
            in_valid = 1'b0;
            exp_v = (k == 4 || k == 6);
            checks++;
            if (feed_valid !== exp_v) begin errors++; $display("FAIL starved_valid k=%0d: got %b want %b", k, feed_valid, exp_v); end
            exp = exp_v && sb.size() != 0 ? sb.pop_front() : 16'h0000;
            checks++;
            if (feed_a !== exp) begin errors++; $display("FAIL starved_data k=%0d: got %h want %h", k, feed_a, exp); end
            checks++;
            if (done !== (k == 10)) begin errors++; $display("FAIL starved_done k=%0d: got %b want %b", k, done, k == 10); end
        end
`ifdef FEEDER_BUBBLE_CNT_EN
        checks++;
        if (bubble_cnt !== 16'd4) begin errors++; $display("FAIL starved_bubbles: got %0d want 4", bubble_cnt); end
`endif
    endtask
    task automatic test_full;
        for (int i = 0; i < 8; i++) push(16'h1000 + 16'(i));
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", in_ready); end
        push(16'hdead);
        checks++;
        if (in_ready !== 1'b0 || sb.size() != 8) begin errors++; $display("FAIL full_holdoff: in_ready=%b queued=%0d, want 0/8", in_ready, sb.size()); end
        test_prefilled_burst(1, "full");
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL full_after: in_ready=%b want 1", in_ready); end
    endtask
    task automatic test_back_to_back;
        test_prefilled_burst(7, "b2b");
        checks++;
        if (sb.size() != 0 || feed_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: left=%0d valid=%b, want 0/0", sb.size(), feed_valid); end
    endtask
    task automatic test_zero_len;
        push(16'h3c00);
        burst_len = 8'd0;
        start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || feed_valid !== 1'b0) begin errors++; $display("FAIL zero_done: done=%b busy=%b valid=%b, want 1/1/0", done, busy, feed_valid); end
        tick;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || feed_valid !== 1'b0) begin errors++; $display("FAIL zero_idle: done=%b busy=%b valid=%b, want 0/0/0", done, busy, feed_valid); end
        test_prefilled_burst(1, "zero_next");
    endtask
    task automatic test_midreset;
        logic [15:0] exp;
        push(16'h5000);
        push(16'h5100);
        push(16'h5200);
        burst_len = 8'd3;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        exp = sb.pop_front();
        checks++;
        if (feed_valid !== 1'b1 || feed_a !== exp) begin errors++; $display("FAIL midrst_first: valid=%b data=%h, want 1/%h", feed_valid, feed_a, exp); end
        reset = 1'b0;
        tick;
        reset = 1'b1;
        sb.delete();
        checks++;
        if (feed_a !== 16'h0 || feed_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL midrst_abort: a=%h v=%b busy=%b rdy=%b done=%b, want 0000/0/0/1/0", feed_a, feed_valid, busy, in_ready, done);
        end
        burst_len = 8'd1;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            in_valid = (k == 4);
            in_data = 16'h3800;
            tick;
            in_valid = 1'b0;
            checks++;
            if (feed_valid !== (k == 5)) begin errors++; $display("FAIL midrst_next_valid k=%0d: got %b want %b", k, feed_valid, k == 5); end
            checks++;
            if (feed_a !== (k == 5 ? 16'h3800 : 16'h0000)) begin errors++; $display("FAIL midrst_next_data k=%0d: got %h", k, feed_a); end
            checks++;
            if (done !== (k == 9)) begin errors++; $display("FAIL midrst_next_done k=%0d: got %b want %b", k, done, k == 9); end
        end
    endtask
    task automatic test_ignore_start;
        logic [15:0] exp;
        int dones = 0;
        push(16'h4400);
        push(16'h4500);
        burst_len = 8'd2;
        start = 1'b1;
        tick;
        start = 1'b0;
        burst_len = 8'd7;
        for (int k = 1; k <= 10; k++) begin
            start = (k == 4 || k == 7);
            tick;
            start = 1'b0;
            checks++;
            if (feed_valid !== (k <= 2)) begin errors++; $display("FAIL ign_valid k=%0d: got %b want %b", k, feed_valid, k <= 2); end
            if (k <= 2) begin
                exp = sb.size() != 0 ? sb.pop_front() : 16'hxxxx;
                checks++;
                if (feed_a !== exp) begin errors++; $display("FAIL ign_data k=%0d: got %h want %h", k, feed_a, exp); end
            end
            checks++;
            if (done !== (k == 6)) begin errors++; $display("FAIL ign_done k=%0d: got %b want %b", k, done, k == 6); end
            checks++;
            if (busy !== (k <= 6)) begin errors++; $display("FAIL ign_busy k=%0d: got %b want %b", k, busy, k <= 6); end
            dones += int'(done);
        end
        checks++;
        if (dones != 1) begin errors++; $display("FAIL ign_done_count: got %0d want 1", dones); end
    endtask
    initial begin
        test_reset;
        test_prefill;
        test_starved;
        test_full;
        test_back_to_back;
        test_zero_len;
        test_midreset;
        test_ignore_start;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
